regfile_mp: RTL

//  Parametrised multi-port integer register file with a write-pending scoreboard and
//  per-port write-to-read forwarding. Replaces the single-read/single-write file

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_mp.sv | 80 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: default widths, register types and zero constant shared by the register file and its bench
package regfile_pkg;
  localparam int DEF_XLEN = 64;
  localparam int DEF_NREG = 32;
  localparam int DEF_AW = $clog2(DEF_NREG);
  typedef logic [DEF_AW-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0] reg_data_t;
  localparam reg_data_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-writer bits; issue sets, writeback clears, set wins on conflict
// ports: clk, rst (async active-low), we_i/waddr_i writeback clears, iss_valid_i/iss_rd_i issue,
//        raddr_i read lookups -> rd_busy_o (raw busy), iss_ready_o; busy_o only with DIFFTEST_EN
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW = DEF_AW,
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NWR-1:0]  we_i,
  input  logic [NWR*AW-1:0] waddr_i,
  input  logic            iss_valid_i,
  input  logic [AW-1:0]   iss_rd_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic            iss_ready_o,
  output logic [NRD-1:0]  rd_busy_o
`ifdef DIFFTEST_EN
  ,output logic [NREG-1:0] busy_o
`endif
);
  logic [NREG-1:0] busy_q, busy_d;
  assign iss_ready_o = !busy_q[iss_rd_i] | (iss_rd_i == '0);
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++)
      if (we_i[k]) busy_d[waddr_i[k*AW +: AW]] = 1'b0;
    if (iss_valid_i && iss_ready_o && iss_rd_i != '0) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_q <= '0;
    else busy_q <= busy_d;
  for (genvar j = 0; j < NRD; j++) begin : g_rb
    assign rd_busy_o[j] = busy_q[raddr_i[j*AW +: AW]];
  end
`ifdef DIFFTEST_EN
  assign busy_o = busy_q;
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with priority writes, write-to-read forwarding and busy scoreboard
// ports: clk, rst (async active-low); we_i/waddr_i/wdata_i NWR write ports (higher index wins);
//        raddr_i -> rdata_o/rbusy_o NRD combinational read ports; iss_valid_i/iss_rd_i/iss_ready_o issue.
// DIFFTEST_EN adds diff_reg_o (all registers) and diff_busy_o (busy vector), straight from state.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int AW = DEF_AW,
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  output logic                iss_ready_o
`ifdef DIFFTEST_EN
  ,output logic [NREG*XLEN-1:0] diff_reg_o,
  output logic [NREG-1:0]      diff_busy_o
`endif
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NRD-1:0] rd_busy;
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWR; k++)
      if (we_i[k]) regs_d[waddr_i[k*AW +: AW]] = wdata_i[k*XLEN +: XLEN];
    regs_d[0] = '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  regfile_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk(clk),
    .rst(rst),
    .we_i(we_i),
    .waddr_i(waddr_i),
    .iss_valid_i(iss_valid_i),
    .iss_rd_i(iss_rd_i),
    .raddr_i(raddr_i),
    .iss_ready_o(iss_ready_o),
    .rd_busy_o(rd_busy)
`ifdef DIFFTEST_EN
    ,.busy_o(diff_busy_o)
`endif
  );
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    logic [XLEN-1:0] fwd;
    assign a = raddr_i[j*AW +: AW];
    // ascending scan so the highest-index matching writer is forwarded
    always_comb begin
      hit = 1'b0;
      fwd = regs_q[a];
      for (int k = 0; k < NWR; k++)
        if (we_i[k] && waddr_i[k*AW +: AW] == a) begin
          hit = 1'b1;
          fwd = wdata_i[k*XLEN +: XLEN];
        end
    end
    assign rdata_o[j*XLEN +: XLEN] = (a == '0) ? '0 : fwd;
    // a writeback landing this cycle resolves the hazard for the reader already
    assign rbusy_o[j] = rd_busy[j] & ~hit;
  end
`ifdef DIFFTEST_EN
  for (genvar i = 0; i < NREG; i++) begin : g_diff
    assign diff_reg_o[i*XLEN +: XLEN] = regs_q[i];
  end
`endif
endmodule
